// File: rtl/weight_fetch_biu_if.sv
// Control, request, response and buffer-write bundle of the weight fetch BIU.
interface weight_fetch_biu_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int OCH_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [AW-1:0]    w3_base;
    logic [AW-1:0]    w1_base;
    logic [OCH_W-1:0] och_idx;
    logic             busy;
    logic             done;
    logic [AW-1:0]    req_addr;
    logic             req_vld;
    logic             req_rdy;
    logic [DW-1:0]    rsp_data;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_en;

    modport master (
        input  start, mode, w3_base, w1_base, och_idx,
        input  req_rdy, rsp_data, rsp_vld,
        output busy, done, req_addr, req_vld, rsp_rdy,
        output wr_addr, wr_data, wr_en
    );

    modport slave (
        output start, mode, w3_base, w1_base, och_idx,
        output req_rdy, rsp_data, rsp_vld,
        input  busy, done, req_addr, req_vld, rsp_rdy,
        input  wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/weight_fetch_biu.sv
// Weight fetch BIU: streams 3x3 and/or 1x1 kernel words of one output
// channel from memory into the weight buffer with bounded outstanding reads.
module weight_fetch_biu #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int CH_WORDS = 16,
    parameter int OCH_W    = 8,
    parameter int MAX_OS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    weight_fetch_biu_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH3,
        FETCH1,
        DRAIN
    } state_e;

    localparam int N3  = 9 * CH_WORDS;
    localparam int ICW = $clog2(N3 + 1);
    localparam int RCW = $clog2(10 * CH_WORDS + 1);
    localparam int OSW = $clog2(MAX_OS) + 1;

    localparam logic [AW-1:0] STRIDE3 = AW'(CH_WORDS * 36);
    localparam logic [AW-1:0] STRIDE1 = AW'(CH_WORDS * 4);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [AW-1:0]    w1_base_q, w1_base_d;
    logic [OCH_W-1:0] och_q, och_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [ICW-1:0]   iss_q, iss_d;
    logic [RCW-1:0]   rx_q, rx_d;
    logic [OSW-1:0]   os_q, os_d;
    logic [5:0]       ch_q, ch_d;
    logic [3:0]       pos_q, pos_d;
    logic             kind_q, kind_d;
    logic             done_q, done_d;

    logic           fetching;
    logic           rsp_acc;
    logic           req_vld;
    logic           req_hs;
    logic           last_iss;
    logic [ICW-1:0] iss_lim;
    logic [RCW-1:0] rx_total;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wdata;

    assign fetching = (state_q == FETCH3) || (state_q == FETCH1);
    assign iss_lim  = (state_q == FETCH3) ? ICW'(N3) : ICW'(CH_WORDS);

    // A response with nothing outstanding is stale (e.g. from before a reset).
    assign rsp_acc  = bus.rsp_vld && (os_q != '0);
    assign req_vld  = fetching && ((os_q < OSW'(MAX_OS)) || rsp_acc);
    assign req_hs   = req_vld && bus.req_rdy;
    assign last_iss = req_hs && (iss_q == iss_lim - 1'b1);

    always_comb begin
        case (mode_q)
            2'b00:   rx_total = RCW'(10 * CH_WORDS);
            2'b01:   rx_total = RCW'(N3);
            2'b10:   rx_total = RCW'(CH_WORDS);
            default: rx_total = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        w1_base_d = w1_base_q;
        och_d     = och_q;
        addr_d    = addr_q;
        iss_d     = iss_q;
        rx_d      = rx_q;
        os_d      = os_q;
        ch_d      = ch_q;
        pos_d     = pos_q;
        kind_d    = kind_q;
        done_d    = 1'b0;

        if (req_hs && !rsp_acc) begin
            os_d = os_q + 1'b1;
        end else if (!req_hs && rsp_acc) begin
            os_d = os_q - 1'b1;
        end

        // Receive side walks channel word, then kernel position, then kind.
        if (rsp_acc) begin
            rx_d = rx_q + 1'b1;
            if (ch_q == 6'(CH_WORDS - 1)) begin
                ch_d = '0;
                if (!kind_q) begin
                    if (pos_q == 4'd8) begin
                        pos_d  = '0;
                        kind_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    w1_base_d = bus.w1_base;
                    och_d     = bus.och_idx;
                    iss_d     = '0;
                    rx_d      = '0;
                    ch_d      = '0;
                    pos_d     = '0;
                    kind_d    = (bus.mode == 2'b10);
                    unique case (bus.mode)
                        2'b00, 2'b01: begin
                            state_d = FETCH3;
                            addr_d  = bus.w3_base
                                    + AW'(bus.och_idx) * STRIDE3;
                        end
                        2'b10: begin
                            state_d = FETCH1;
                            addr_d  = bus.w1_base
                                    + AW'(bus.och_idx) * STRIDE1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            FETCH3: begin
                if (req_hs) begin
                    addr_d = addr_q + AW'(4);
                    iss_d  = iss_q + 1'b1;
                end
                if (last_iss) begin
                    iss_d = '0;
                    if (mode_q == 2'b00) begin
                        state_d = FETCH1;
                        addr_d  = w1_base_q + AW'(och_q) * STRIDE1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            FETCH1: begin
                if (req_hs) begin
                    addr_d = addr_q + AW'(4);
                    iss_d  = iss_q + 1'b1;
                end
                if (last_iss) begin
                    iss_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rx_d == rx_total) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            w1_base_q <= '0;
            och_q     <= '0;
            addr_q    <= '0;
            iss_q     <= '0;
            rx_q      <= '0;
            os_q      <= '0;
            ch_q      <= '0;
            pos_q     <= '0;
            kind_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            w1_base_q <= w1_base_d;
            och_q     <= och_d;
            addr_q    <= addr_d;
            iss_q     <= iss_d;
            rx_q      <= rx_d;
            os_q      <= os_d;
            ch_q      <= ch_d;
            pos_q     <= pos_d;
            kind_q    <= kind_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        wa                   = '0;
        wa[AW-1]             = kind_q;
        wa[AW-2 -: OCH_W]    = och_q;
        wa[11:6]             = {2'b00, pos_q};
        wa[5:0]              = ch_q;
    end

    assign wdata        = bus.rsp_data;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.req_addr = addr_q;
    assign bus.req_vld  = req_vld;
    assign bus.rsp_rdy  = 1'b1;
    assign bus.wr_en    = rsp_acc;
    assign bus.wr_data  = wdata;
    assign bus.wr_addr  = wa;
endmodule

// File: doc/weight_fetch_biu.md
WEIGHT_FETCH_BIU -- requirements
Module: weight_fetch_biu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning), one per line:
- AW, 32, address width.
- DW, 32, data word width (4 x 8-bit weights).
- CH_WORDS, 16, words per kernel position per output channel (in_ch/4).
- OCH_W, 8, output-channel index width.
- MAX_OS, 8, maximum outstanding read requests (power of two, 2..64).
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle fetch start pulse.
- mode, in, 2, 00 = 3x3 then 1x1; 01 = 3x3 only; 10 = 1x1 only; 11 = none.
- w3_base, in, AW, 3x3 weight base byte address.
- w1_base, in, AW, 1x1 weight base byte address.
- och_idx, in, OCH_W, output-channel index.
- busy, out, 1, high from accepted start to done.
- done, out, 1, one-cycle completion pulse.
- req_addr, out, AW, read request byte address.
- req_vld, out, 1, request valid.
- req_rdy, in, 1, request ready.
- rsp_data, in, DW, read response data.
- rsp_vld, in, 1, response valid.
- rsp_rdy, out, 1, response ready, tied to 1.
- wr_addr, out, AW, weight buffer write address.
- wr_data, out, DW, weight buffer write data.
- wr_en, out, 1, weight buffer write enable.

Function
REQ-004 FSM states SHALL be IDLE, FETCH3, FETCH1 and DRAIN.
REQ-005 In IDLE, start SHALL latch mode, w3_base, w1_base and och_idx and move to the next state:
- mode 00 or 01 -> FETCH3.
- mode 10 -> FETCH1.
- mode 11 -> IDLE, with a done pulse the next cycle and no requests issued.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 On entering FETCH3, req_addr SHALL be w3_base + och_idx*CH_WORDS*36. On entering FETCH1, req_addr SHALL be w1_base + och_idx*CH_WORDS*4. Both SHALL be computed modulo 2^AW.
REQ-008 Each request handshake (req_vld & req_rdy) SHALL advance req_addr by 4 and the issue counter by 1.
REQ-009 FETCH3 SHALL issue exactly 9*CH_WORDS requests and FETCH1 exactly CH_WORDS requests. After the last handshake the FSM SHALL move to FETCH1 (mode 00) or DRAIN (modes 01, 10).
REQ-010 req_vld SHALL be high in FETCH3/FETCH1 only while os_cnt < MAX_OS, or os_cnt == MAX_OS with rsp_vld high in the same cycle.
- os_cnt SHALL increment on a request handshake and decrement on a response.
- A simultaneous request and response SHALL leave os_cnt unchanged.
REQ-011 While req_vld=1 and req_rdy=0, req_addr SHALL remain stable.
REQ-012 DRAIN SHALL wait until all expected responses (request total for the mode) are received, then go to IDLE and pulse done for one cycle.
REQ-013 wr_en SHALL equal rsp_vld and wr_data SHALL equal rsp_data, combinationally (zero latency).
REQ-014 wr_addr fields:
- [AW-1] = kind (0 = 3x3, 1 = 1x1).
- [AW-2 : AW-1-OCH_W] = latched och_idx.
- [11:6] = kernel position 0..8 (0 for 1x1).
- [5:0] = channel word 0..CH_WORDS-1.
- All other bits = 0.
REQ-015 The receive channel counter SHALL wrap at CH_WORDS-1. The position counter SHALL increment on that wrap and wrap at 8. Kind SHALL switch to 1 after 9*CH_WORDS responses (mode 00), or be 1 from the start (mode 10).
REQ-016 Responses arriving with no outstanding requests SHALL be ignored: no wr_en and no counter change.
REQ-017 busy SHALL be 1 in FETCH3, FETCH1 and DRAIN, and 0 in IDLE.

Reset
REQ-018 In the cycle after rst=1, the block SHALL be in IDLE with all counters 0 and: req_addr=0, req_vld=0, busy=0, done=0.
REQ-019 A reset asserted mid-fetch SHALL abandon the operation immediately. Responses arriving after reset SHALL produce no wr_en.

Verification
REQ-020 The bench SHALL cover at least these scenarios (defaults, req_rdy=1, 2-cycle response latency):
- mode 00, w3_base=0x1000, w1_base=0x8000, och_idx=2 -> first req_addr 0x1480, 144 requests, then 0x8080; 160 wr_en; done 1 cycle after the 160th response.
- mode 10, och_idx=0 -> 16 requests from w1_base; wr_addr[31]=1, [11:6]=0 on all writes.
- Responses stalled 20 cycles -> exactly 8 requests issued, then req_vld=0 until the first response returns.
- req_rdy toggling 50% randomly -> req_addr held while stalled, no skipped or duplicate addresses.
- start re-pulsed while busy -> ignored; mode 11 -> done on the next cycle, zero requests.
- rst pulsed after 40 requests -> busy=0 next cycle; a new start refetches cleanly from the base address.
